mux_4_to_1: RTL and testbench

- 4-to-1 single-bit multiplexer. Two select bits (A, B) choose one of four data inputs I[3:0].
- The primary output Y is purely combinational and is valid with no clock activity.
- A registered copy of the output and of the select (Y_q, sel_q) is also provided for downstream synchronous logic in the datapath.
- Leaf block; no submodules required.

---
 rtl/mux_4_to_1.sv | 25 ++
 tb/tb_mux_4_to_1.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_4_to_1.sv
// mux_4_to_1: 4-to-1 single-bit mux with combinational output and optional registered copy
module mux_4_to_1 #(
  parameter logic RESET_VAL = 1'b0,
  parameter bit   REG_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] I,
  input  logic       A,
  input  logic       B,
  output logic       Y,
  output logic       Y_q,
  output logic [1:0] sel_q
);
  // nested ternaries keep X-merge semantics when a select bit is unknown
  assign Y = A ? (B ? I[3] : I[2]) : (B ? I[1] : I[0]);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      Y_q   <= RESET_VAL;
      sel_q <= 2'b00;
    end else if (REG_EN) begin
      Y_q   <= Y;
      sel_q <= {A, B};
    end
endmodule

// File: tb/tb_mux_4_to_1.sv
// tb_mux_4_to_1: scoreboard bench for mux_4_to_1, with a second REG_EN=0 instance
`timescale 1ns/1ps
module tb_mux_4_to_1;
  typedef struct packed {
    logic       y;
    logic [1:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] I = 4'b0000;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       Y, Y_q, y0, y_q0;
  logic [1:0] sel_q, sel_q0;
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;

  mux_4_to_1 dut (
    .clk(clk), .reset(reset), .I(I), .A(A), .B(B),
    .Y(Y), .Y_q(Y_q), .sel_q(sel_q)
  );

  mux_4_to_1 #(.RESET_VAL(1'b1), .REG_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .I(I), .A(A), .B(B),
    .Y(y0), .Y_q(y_q0), .sel_q(sel_q0)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic logic model(input logic [3:0] d, input logic [1:0] s);
    logic [3:0] t;
    t = d >> s;
    return t[0];
  endfunction

  task automatic check_dis(input string name);
    n_checks++;
    if (y_q0 !== 1'b1 || sel_q0 !== 2'b00) begin
      n_fail++;
      $display("FAIL %s: reg_en0 Y_q=%b sel_q=%b, expected Y_q=1 sel_q=00", name, y_q0, sel_q0);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (Y_q !== 1'b0 || sel_q !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_async: Y_q=%b sel_q=%b, expected 0 00", Y_q, sel_q);
    end
    check_dis("reset_async");
    clk_run = 1'b1;
    I = 4'b1111; A = 1'b1; B = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (Y_q !== 1'b0 || sel_q !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hold: Y_q=%b sel_q=%b, expected 0 00", Y_q, sel_q);
    end
    check_dis("reset_hold");
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_sweep();
    exp_t e;
    clk_run = 1'b0;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      {A, B, I} = v;
      sb.push_back('{y: model(v[3:0], v[5:4]), sel: v[5:4]});
      #10;
      e = sb.pop_front();
      n_checks++;
      if (Y !== e.y || y0 !== e.y) begin
        n_fail++;
        $display("FAIL sweep i=%0d: Y=%b Y(reg_en0)=%b, expected %b", i, Y, y0, e.y);
      end
    end
    check_dis("sweep");
  endtask

  task automatic test_select_isolation();
    logic [3:0] pats [2] = '{4'b0001, 4'b1110};
    logic [3:0] outs [2] = '{4'b0001, 4'b1110};
    exp_t e;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++) begin
        logic [1:0] sv;
        logic [3:0] ov;
        sv = 2'(s);
        ov = outs[p];
        I = pats[p];
        {A, B} = sv;
        sb.push_back('{y: ov[s], sel: sv});
        #10;
        e = sb.pop_front();
        n_checks++;
        if (Y !== e.y) begin
          n_fail++;
          $display("FAIL isolation I=%b sel=%b: Y=%b, expected %b", I, sv, Y, e.y);
        end
      end
  endtask

  task automatic test_independence();
    clk_run = 1'b0;
    reset = 1'b1;
    I = 4'b0100; A = 1'b1; B = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (Y !== 1'b1) begin
        n_fail++;
        $display("FAIL independence step=%0d reset=%b: Y=%b, expected 1", k, reset, Y);
      end
      reset = ~reset;
    end
    reset = 1'b0;
    clk_run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    I = 4'b1000; A = 1'b1; B = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (Y_q !== 1'b1 || sel_q !== 2'b11) begin
      n_fail++;
      $display("FAIL async_pre: Y_q=%b sel_q=%b, expected 1 11", Y_q, sel_q);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (Y_q !== 1'b0 || sel_q !== 2'b00) begin
      n_fail++;
      $display("FAIL async_midcycle: Y_q=%b sel_q=%b, expected 0 00", Y_q, sel_q);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (Y_q !== 1'b0 || sel_q !== 2'b00) begin
      n_fail++;
      $display("FAIL async_hold: Y_q=%b sel_q=%b, expected 0 00", Y_q, sel_q);
    end
    check_dis("async_hold");
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_latency();
    @(negedge clk);
    I = 4'b1000; A = 1'b1; B = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (Y_q !== 1'b1 || sel_q !== 2'b11) begin
      n_fail++;
      $display("FAIL latency_edge_n: Y_q=%b sel_q=%b, expected 1 11", Y_q, sel_q);
    end
    B = 1'b0;
    #1;
    n_checks++;
    if (Y !== 1'b0 || Y_q !== 1'b1 || sel_q !== 2'b11) begin
      n_fail++;
      $display("FAIL latency_between: Y=%b Y_q=%b sel_q=%b, expected 0 1 11", Y, Y_q, sel_q);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (Y_q !== 1'b0 || sel_q !== 2'b10) begin
      n_fail++;
      $display("FAIL latency_edge_n1: Y_q=%b sel_q=%b, expected 0 10", Y_q, sel_q);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 40; c++) begin
      logic [5:0] v;
      @(negedge clk);
      v = 6'($urandom_range(63));
      {A, B, I} = v;
      sb.push_back('{y: model(v[3:0], v[5:4]), sel: v[5:4]});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (Y_q !== e.y || sel_q !== e.sel) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d: Y_q=%b sel_q=%b, expected %b %b", c, Y_q, sel_q, e.y, e.sel);
      end
      check_dis("back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_select_isolation();
    test_independence();
    test_async_reset();
    test_latency();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
